// File: rtl/xpoint_sched.sv
// Crosspoint scheduler: decodes turn bits, round-robin arbitrates H/V flits that target
// the same output, and registers switched flits into one-entry output slots.
module xpoint_sched #(
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned TURN_BIT  = FLIT_SIZE - 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] h_in_flit,
  input  logic                 h_in_valid,
  output logic                 h_in_ready,
  input  logic [FLIT_SIZE-1:0] v_in_flit,
  input  logic                 v_in_valid,
  output logic                 v_in_ready,
  output logic [FLIT_SIZE-1:0] h_out_flit,
  output logic                 h_out_valid,
  input  logic                 h_out_ready,
  output logic [FLIT_SIZE-1:0] v_out_flit,
  output logic                 v_out_valid,
  input  logic                 v_out_ready,
  output logic                 cross_enable,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic [FLIT_SIZE-1:0] r_h_flit, r_v_flit;
  logic                 r_h_valid, r_v_valid;
  logic                 r_prio;  // 0 = H wins the next conflict, 1 = V
  logic [CNT_W-1:0]     r_cnt;

  logic w_h_turn, w_v_turn;
  logic w_h_free, w_v_free;
  logic w_h_tgt_free, w_v_tgt_free;
  logic w_conflict, w_conflict_granted;
  logic w_grant_h, w_grant_v;
  logic w_h_load, w_v_load;
  logic [FLIT_SIZE-1:0] w_h_load_flit, w_v_load_flit;

  assign w_h_turn = h_in_flit[TURN_BIT];
  assign w_v_turn = v_in_flit[TURN_BIT];

  assign w_h_free = !r_h_valid || h_out_ready;
  assign w_v_free = !r_v_valid || v_out_ready;

  // H turning goes to the V slot; V turning goes to the H slot.
  assign w_h_tgt_free = w_h_turn ? w_v_free : w_h_free;
  assign w_v_tgt_free = w_v_turn ? w_h_free : w_v_free;

  // Same target slot exactly when the two turn bits differ.
  assign w_conflict = h_in_valid && v_in_valid && (w_h_turn != w_v_turn);

  always_comb begin
    w_grant_h          = 1'b0;
    w_grant_v          = 1'b0;
    w_conflict_granted = 1'b0;
    if (w_conflict) begin
      if (w_h_tgt_free) begin
        w_conflict_granted = 1'b1;
        w_grant_h          = !r_prio;
        w_grant_v          = r_prio;
      end
    end else begin
      w_grant_h = h_in_valid && w_h_tgt_free;
      w_grant_v = v_in_valid && w_v_tgt_free;
    end
  end

  assign h_in_ready   = w_grant_h;
  assign v_in_ready   = w_grant_v;
  assign cross_enable = (w_grant_h && w_h_turn) || (w_grant_v && w_v_turn);

  assign w_h_load      = (w_grant_h && !w_h_turn) || (w_grant_v && w_v_turn);
  assign w_v_load      = (w_grant_v && !w_v_turn) || (w_grant_h && w_h_turn);
  assign w_h_load_flit = (w_grant_h && !w_h_turn) ? h_in_flit : v_in_flit;
  assign w_v_load_flit = (w_grant_v && !w_v_turn) ? v_in_flit : h_in_flit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_flit  <= '0;
      r_h_valid <= 1'b0;
    end else if (w_h_load) begin
      r_h_flit  <= w_h_load_flit;
      r_h_valid <= 1'b1;
    end else if (h_out_ready) begin
      r_h_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_flit  <= '0;
      r_v_valid <= 1'b0;
    end else if (w_v_load) begin
      r_v_flit  <= w_v_load_flit;
      r_v_valid <= 1'b1;
    end else if (v_out_ready) begin
      r_v_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_cnt  <= '0;
    end else if (w_conflict_granted) begin
      r_prio <= !r_prio;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign h_out_flit   = r_h_flit;
  assign h_out_valid  = r_h_valid;
  assign v_out_flit   = r_v_flit;
  assign v_out_valid  = r_v_valid;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_xpoint_sched.sv
// Bench for xpoint_sched: vector table with an output scoreboard, plus reset and
// counter-saturation sequences on a narrow-counter second instance.
module tb_xpoint_sched;

  localparam int unsigned FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] h_in_flit = '0, v_in_flit = '0;
  logic          h_in_valid = 1'b0, v_in_valid = 1'b0;
  logic          h_out_ready = 1'b1, v_out_ready = 1'b1;

  logic          h_in_ready, v_in_ready, h_out_valid, v_out_valid, cross_enable;
  logic [FW-1:0] h_out_flit, v_out_flit;
  logic [15:0]   conflict_cnt;

  logic          s_h_in_ready, s_v_in_ready, s_h_out_valid, s_v_out_valid, s_cross_enable;
  logic [FW-1:0] s_h_out_flit, s_v_out_flit;
  logic [1:0]    s_conflict_cnt;

  always #5 clk = ~clk;

  xpoint_sched #(.FLIT_SIZE(FW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .h_in_flit(h_in_flit), .h_in_valid(h_in_valid), .h_in_ready(h_in_ready),
    .v_in_flit(v_in_flit), .v_in_valid(v_in_valid), .v_in_ready(v_in_ready),
    .h_out_flit(h_out_flit), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
    .v_out_flit(v_out_flit), .v_out_valid(v_out_valid), .v_out_ready(v_out_ready),
    .cross_enable(cross_enable), .conflict_cnt(conflict_cnt)
  );

  xpoint_sched #(.FLIT_SIZE(FW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .h_in_flit(h_in_flit), .h_in_valid(h_in_valid), .h_in_ready(s_h_in_ready),
    .v_in_flit(v_in_flit), .v_in_valid(v_in_valid), .v_in_ready(s_v_in_ready),
    .h_out_flit(s_h_out_flit), .h_out_valid(s_h_out_valid), .h_out_ready(h_out_ready),
    .v_out_flit(s_v_out_flit), .v_out_valid(s_v_out_valid), .v_out_ready(v_out_ready),
    .cross_enable(s_cross_enable), .conflict_cnt(s_conflict_cnt)
  );

  typedef struct {
    logic [FW-1:0] hf;
    logic          hv;
    logic [FW-1:0] vf;
    logic          vv;
    logic          hor, vor;
    logic          ehr, evr, ece;
    logic          ehov;
    logic [FW-1:0] ehof;
    logic          evov;
    logic [FW-1:0] evof;
    logic [15:0]   ecnt;
  } vec_t;

  typedef struct {
    int            idx;
    logic          hov;
    logic [FW-1:0] hof;
    logic          vov;
    logic [FW-1:0] vof;
    logic [15:0]   cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [FW-1:0] hf, input logic hv, input logic [FW-1:0] vf,
                              input logic vv, input logic hor, input logic vor,
                              input logic ehr, input logic evr, input logic ece,
                              input logic ehov, input logic [FW-1:0] ehof,
                              input logic evov, input logic [FW-1:0] evof,
                              input logic [15:0] ecnt);
    vec_t v;
    v.hf = hf; v.hv = hv; v.vf = vf; v.vv = vv; v.hor = hor; v.vor = vor;
    v.ehr = ehr; v.evr = evr; v.ece = ece;
    v.ehov = ehov; v.ehof = ehof; v.evov = evov; v.evof = evof; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check_outputs(input exp_t e);
    chk($sformatf("v%0d h_out_valid", e.idx), 32'(h_out_valid), 32'(e.hov));
    chk($sformatf("v%0d v_out_valid", e.idx), 32'(v_out_valid), 32'(e.vov));
    if (e.hov) chk($sformatf("v%0d h_out_flit", e.idx), 32'(h_out_flit), 32'(e.hof));
    if (e.vov) chk($sformatf("v%0d v_out_flit", e.idx), 32'(v_out_flit), 32'(e.vof));
    chk($sformatf("v%0d conflict_cnt", e.idx), 32'(conflict_cnt), 32'(e.cnt));
  endtask

  initial begin
    exp_t e;

    //               hf      hv vf      vv hor vor hr vr ce  hov hof     vov vof     cnt
    vecs.push_back(mk(16'h0001, 1, 16'h0002, 1, 1, 1, 1, 1, 0, 1, 16'h0001, 1, 16'h0002, 0));
    vecs.push_back(mk(16'h8011, 1, 16'h8022, 1, 1, 1, 1, 1, 1, 1, 16'h8022, 1, 16'h8011, 0));
    // Conflict on the H slot: grants alternate H, V, H, V
    vecs.push_back(mk(16'h0031, 1, 16'h8032, 1, 1, 1, 1, 0, 0, 1, 16'h0031, 0, 16'h0000, 1));
    vecs.push_back(mk(16'h0031, 1, 16'h8032, 1, 1, 1, 0, 1, 1, 1, 16'h8032, 0, 16'h0000, 2));
    vecs.push_back(mk(16'h0031, 1, 16'h8032, 1, 1, 1, 1, 0, 0, 1, 16'h0031, 0, 16'h0000, 3));
    vecs.push_back(mk(16'h0031, 1, 16'h8032, 1, 1, 1, 0, 1, 1, 1, 16'h8032, 0, 16'h0000, 4));
    // Blocked conflict: H slot full and stalled
    vecs.push_back(mk(16'h0031, 1, 16'h8032, 1, 0, 1, 0, 0, 0, 1, 16'h8032, 0, 16'h0000, 4));
    // Backpressure on H for three cycles, then same-cycle drain and refill
    vecs.push_back(mk(16'h0041, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 1, 16'h8032, 0, 16'h0000, 4));
    vecs.push_back(mk(16'h0041, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 1, 16'h8032, 0, 16'h0000, 4));
    vecs.push_back(mk(16'h0041, 1, 16'h0000, 0, 0, 1, 0, 0, 0, 1, 16'h8032, 0, 16'h0000, 4));
    vecs.push_back(mk(16'h0041, 1, 16'h0000, 0, 1, 1, 1, 0, 0, 1, 16'h0041, 0, 16'h0000, 4));
    // Blocked conflict left prio at H
    vecs.push_back(mk(16'h0051, 1, 16'h8052, 1, 1, 1, 1, 0, 0, 1, 16'h0051, 0, 16'h0000, 5));
    vecs.push_back(mk(16'h0000, 0, 16'h0062, 1, 1, 0, 0, 1, 0, 0, 16'h0000, 1, 16'h0062, 5));
    // Conflict on the V slot, full and stalled, then freed: prio is V now
    vecs.push_back(mk(16'h8073, 1, 16'h0072, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0062, 5));
    vecs.push_back(mk(16'h8073, 1, 16'h0072, 1, 1, 1, 0, 1, 0, 0, 16'h0000, 1, 16'h0072, 6));
    vecs.push_back(mk(16'h0081, 1, 16'h0082, 1, 0, 1, 1, 1, 0, 1, 16'h0081, 1, 16'h0082, 6));

    // Reset state
    #2;
    chk("rst h_out_valid", 32'(h_out_valid), 0);
    chk("rst v_out_valid", 32'(v_out_valid), 0);
    chk("rst h_out_flit", 32'(h_out_flit), 0);
    chk("rst v_out_flit", 32'(v_out_flit), 0);
    chk("rst conflict_cnt", 32'(conflict_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb.size() > 0) check_outputs(sb.pop_front());
      h_in_flit = vecs[i].hf; h_in_valid = vecs[i].hv;
      v_in_flit = vecs[i].vf; v_in_valid = vecs[i].vv;
      h_out_ready = vecs[i].hor; v_out_ready = vecs[i].vor;
      #1;
      chk($sformatf("v%0d h_in_ready", i), 32'(h_in_ready), 32'(vecs[i].ehr));
      chk($sformatf("v%0d v_in_ready", i), 32'(v_in_ready), 32'(vecs[i].evr));
      chk($sformatf("v%0d cross_enable", i), 32'(cross_enable), 32'(vecs[i].ece));
      e.idx = i; e.hov = vecs[i].ehov; e.hof = vecs[i].ehof;
      e.vov = vecs[i].evov; e.vof = vecs[i].evof; e.cnt = vecs[i].ecnt;
      sb.push_back(e);
    end

    // Hold both full slots, then reset asynchronously between edges
    @(negedge clk);
    h_in_valid = 1'b0; v_in_valid = 1'b0; h_out_ready = 1'b0; v_out_ready = 1'b0;
    if (sb.size() > 0) check_outputs(sb.pop_front());
    #2 rst = 1'b1;
    #1;
    chk("arst h_out_valid", 32'(h_out_valid), 0);
    chk("arst v_out_valid", 32'(v_out_valid), 0);
    chk("arst h_out_flit", 32'(h_out_flit), 0);
    chk("arst v_out_flit", 32'(v_out_flit), 0);
    chk("arst conflict_cnt", 32'(conflict_cnt), 0);
    #1 rst = 1'b0;

    // Continuous conflict after reset: H wins first, counters step, narrow one saturates
    @(negedge clk);
    h_in_flit = 16'h0001; v_in_flit = 16'h8002;
    h_in_valid = 1'b1; v_in_valid = 1'b1; h_out_ready = 1'b1; v_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("sat%0d h_in_ready", k), 32'(h_in_ready), 32'((k % 2) == 0));
      chk($sformatf("sat%0d v_in_ready", k), 32'(v_in_ready), 32'((k % 2) == 1));
      chk($sformatf("sat%0d narrow h_in_ready", k), 32'(s_h_in_ready), 32'((k % 2) == 0));
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d conflict_cnt", k), 32'(conflict_cnt), 32'(k + 1));
      chk($sformatf("sat%0d narrow conflict_cnt", k), 32'(s_conflict_cnt),
          32'((k + 1 > 3) ? 3 : k + 1));
    end

    if (sb.size() != 0) chk("scoreboard drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
